// File: rtl/sip_shift_accumulator.sv
// -----------------------------------------------------------------------------
// sip_shift_accumulator
//
// Bit-serial shift accumulator sitting behind the per-PE dot-product adder.
// Each input beat carries one signed partial dot product (one 2-bit act slice
// times one 2-bit weight slice) plus the combined slice significance. The
// partial is sign-extended, left-shifted by that significance and summed over
// a group of beats framed by i_first / i_last. The finished sum is presented
// through a one-entry valid/ready output register.
//
// Ports:
//   i_CLK     clock, all state on rising edge
//   i_RSTn    asynchronous active-low reset
//   i_clear   synchronous abort of the open group and any pending result
//   i_valid   input beat valid
//   o_ready   block can accept a beat (combinational from i_ready)
//   i_psum    signed partial sum, IN_W bits
//   i_shift   left-shift amount, SHIFT_W bits
//   i_first   beat starts a group
//   i_last    beat ends a group
//   o_valid   o_result holds an unconsumed result
//   i_ready   downstream accepts result
//   o_result  signed accumulated result, ACC_W bits
//   o_err     sticky protocol-error flag (cleared only by reset)
//
// State  | meaning
// -------+----------------------------------------------
// IDLE   | no group open, next accepted beat opens one
// ACCUM  | group open, acc holds the running sum
// -----------------------------------------------------------------------------
module sip_shift_accumulator #(
    parameter int IN_W    = 9,
    parameter int SHIFT_W = 4,
    parameter int ACC_W   = 32
) (
    input  logic               i_CLK,
    input  logic               i_RSTn,
    input  logic               i_clear,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [IN_W-1:0]    i_psum,
    input  logic [SHIFT_W-1:0] i_shift,
    input  logic               i_first,
    input  logic               i_last,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [ACC_W-1:0]   o_result,
    output logic               o_err
);

    localparam int EXT_W = ACC_W - IN_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [ACC_W-1:0]   result_nxt;
    logic               valid_nxt;
    logic               err_nxt;
    logic [ACC_W-1:0]   term;
    logic [ACC_W-1:0]   sum;
    logic               accept;
    logic               opens_group;
    logic               framing_err;

    // A full output register only blocks input when downstream is also
    // stalled; a draining register can take a new result in the same cycle.
    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;

    // Bits shifted past ACC_W are dropped: plain mod 2^ACC_W arithmetic.
    assign term = {{EXT_W{i_psum[IN_W-1]}}, i_psum} << i_shift;

    // A beat arriving in IDLE always starts fresh, even without i_first;
    // an i_first inside an open group throws away the old running sum.
    assign opens_group = (state == ST_IDLE) || i_first;
    assign sum         = opens_group ? term : acc + term;
    assign framing_err = (state == ST_IDLE) != i_first;

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        result_nxt = o_result;
        valid_nxt  = o_valid;
        err_nxt    = o_err;

        if (i_clear) begin
            state_nxt = ST_IDLE;
            acc_nxt   = '0;
            valid_nxt = 1'b0;
        end else begin
            if (o_valid && i_ready) begin
                valid_nxt = 1'b0;
            end
            if (accept) begin
                if (framing_err) begin
                    err_nxt = 1'b1;
                end
                if (i_last) begin
                    result_nxt = sum;
                    valid_nxt  = 1'b1;
                    acc_nxt    = '0;
                    state_nxt  = ST_IDLE;
                end else begin
                    acc_nxt   = sum;
                    state_nxt = ST_ACCUM;
                end
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state    <= ST_IDLE;
            acc      <= '0;
            o_result <= '0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            o_result <= result_nxt;
            o_valid  <= valid_nxt;
            o_err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_sip_shift_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sip_shift_accumulator
//
// Bench for sip_shift_accumulator. A small reference model tracks the group
// sum as beats are accepted and pushes each finished result onto a queue;
// a negedge monitor pops and compares whenever the DUT hands a result over.
// -----------------------------------------------------------------------------
module tb_sip_shift_accumulator;

    localparam int IN_W    = 9;
    localparam int SHIFT_W = 4;
    localparam int ACC_W   = 32;

    logic               i_CLK;
    logic               i_RSTn;
    logic               i_clear;
    logic               i_valid;
    logic               o_ready;
    logic [IN_W-1:0]    i_psum;
    logic [SHIFT_W-1:0] i_shift;
    logic               i_first;
    logic               i_last;
    logic               o_valid;
    logic               i_ready;
    logic [ACC_W-1:0]   o_result;
    logic               o_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [ACC_W-1:0] sb_q[$];
    logic [ACC_W-1:0] m_acc;
    bit               m_open;

    sip_shift_accumulator #(
        .IN_W   (IN_W),
        .SHIFT_W(SHIFT_W),
        .ACC_W  (ACC_W)
    ) dut (
        .i_CLK   (i_CLK),
        .i_RSTn  (i_RSTn),
        .i_clear (i_clear),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_psum  (i_psum),
        .i_shift (i_shift),
        .i_first (i_first),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_result(o_result),
        .o_err   (o_err)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", tag, obs, $signed(obs), exp, $signed(exp));
        end
    endtask

    // Handover happens at the next rising edge when o_valid && i_ready;
    // a clear while o_valid throws the pending result away.
    always @(negedge i_CLK) begin
        if (i_RSTn && o_valid && (i_ready || i_clear)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else if (i_clear) begin
                void'(sb_q.pop_front());
            end else begin
                chk("result", o_result, sb_q.pop_front());
            end
        end
    end

    // Offer one beat from just after a rising edge; returns just after the
    // edge at which it was accepted, with the model updated.
    task automatic send(input int psum, input int shift, input bit first, input bit last);
        logic [ACC_W-1:0] t;
        bit               got;
        i_valid = 1'b1;
        i_psum  = psum[IN_W-1:0];
        i_shift = shift[SHIFT_W-1:0];
        i_first = first;
        i_last  = last;
        got     = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge i_CLK);
            if (o_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("accept_timeout", 0, 1);
        end else begin
            t = 32'(psum) << shift;
            if (!m_open || first) m_acc = t;
            else                  m_acc = m_acc + t;
            if (last) begin
                sb_q.push_back(m_acc);
                m_acc  = '0;
                m_open = 1'b0;
            end else begin
                m_open = 1'b1;
            end
        end
        @(posedge i_CLK);
        #1;
        i_valid = 1'b0;
        i_first = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_acc  = '0;
        m_open = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_RSTn  = 1'b0;
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_psum  = '0;
        i_shift = '0;
        i_first = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        model_reset();

        repeat (2) @(posedge i_CLK);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_result", o_result, 0);
        chk("rst_err", o_err, 0);
        chk("rst_ready", o_ready, 1);
        i_RSTn = 1'b1;
        tick();

        // Three-beat group: 20 - 48 + 1
        send(5, 2, 1, 0);
        chk("g3_no_early_valid", o_valid, 0);
        send(-3, 4, 0, 0);
        chk("g3_no_early_valid2", o_valid, 0);
        send(1, 0, 0, 1);
        chk("g3_latency_valid", o_valid, 1);
        chk("g3_result", o_result, -27);
        chk("g3_err", o_err, 0);
        tick();
        chk("g3_valid_drop", o_valid, 0);
        chk("g3_result_hold", o_result, -27);

        // Single-beat group, largest negative partial at shift 12
        send(-256, 12, 1, 1);
        chk("single_result", o_result, 32'hFFF0_0000);
        chk("single_valid", o_valid, 1);
        tick();
        chk("single_valid_drop", o_valid, 0);

        // Back-to-back groups at full rate
        send(100, 15, 1, 1);
        send(-1, 15, 1, 0);
        send(255, 3, 0, 1);
        send(7, 1, 1, 1);
        tick();

        // Backpressure: result held, beats not absorbed
        i_ready = 1'b0;
        send(7, 0, 1, 1);
        i_valid = 1'b1;
        i_psum  = 9'd2;
        i_shift = '0;
        i_first = 1'b1;
        i_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_CLK);
            chk("bp_ready", o_ready, 0);
            chk("bp_valid", o_valid, 1);
            chk("bp_result", o_result, 7);
        end
        tick();
        i_ready = 1'b1;
        send(2, 0, 1, 1);
        chk("bp_drain_load_valid", o_valid, 1);
        chk("bp_drain_load_result", o_result, 2);
        tick();

        // Clear mid-group with a competing last beat
        send(8, 2, 1, 0);
        send(8, 0, 0, 0);
        i_clear = 1'b1;
        i_valid = 1'b1;
        i_psum  = 9'd50;
        i_shift = '0;
        i_first = 1'b0;
        i_last  = 1'b1;
        tick();
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        m_acc   = '0;
        m_open  = 1'b0;
        chk("clr_beat_dropped", o_valid, 0);
        send(3, 0, 1, 1);
        chk("clr_new_result", o_result, 3);
        chk("clr_err_clean", o_err, 0);
        tick();

        // Clear while a result is pending
        i_ready = 1'b0;
        send(6, 0, 1, 1);
        chk("clrv_valid", o_valid, 1);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("clrv_valid_drop", o_valid, 0);
        chk("clrv_result_hold", o_result, 6);
        i_ready = 1'b1;
        tick();

        // Protocol errors
        send(4, 1, 0, 0);
        chk("err_implied_first", o_err, 1);
        send(1, 0, 0, 1);
        chk("err_implied_result", o_result, 9);
        send(10, 0, 1, 0);
        send(100, 0, 1, 0);
        send(5, 1, 0, 1);
        chk("err_restart_result", o_result, 110);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk("err_sticky", o_err, 1);
        tick();

        // Async reset with a pending result, between clock edges
        i_ready = 1'b0;
        send(9, 0, 1, 1);
        #2;
        i_RSTn = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_result", o_result, 0);
        chk("arst_err", o_err, 0);
        @(negedge i_CLK);
        i_RSTn  = 1'b1;
        i_ready = 1'b1;
        tick();

        // Async reset mid-group: the open sum must be lost
        send(20, 0, 1, 0);
        #2;
        i_RSTn = 1'b0;
        model_reset();
        @(negedge i_CLK);
        i_RSTn = 1'b1;
        tick();
        send(5, 0, 1, 1);
        chk("arst_fresh_result", o_result, 5);
        chk("arst_fresh_err", o_err, 0);
        tick();
        tick();

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
